mem_stage: RTL and testbench



---
 rtl/core_pkg.sv | 21 ++
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_align.sv | 61 ++++++
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the memory stage: memOper field layout,
// load/store size codes and the request FSM state type.
package core_pkg;

  // memOper bit positions
  localparam int MEMOP_EN_BIT = 4;
  localparam int MEMOP_WE_BIT = 3;

  // memOper[2:0] size/sign codes
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic {
    MS_IDLE,
    MS_BUSY
  } ms_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port. The memory stage is the master; the memory
// (or the bench) is the slave.
interface mem_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, replicated store data,
// misalignment detection and sign/zero-extended load data.
module mem_align
  import core_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half out of the read word
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Decode size code into lanes; unknown codes are flagged misaligned
  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = sdata_i;
    misaligned_o = 1'b1;
    ldata_o      = 32'h0;
    case (size_i)
      MEM_B, MEM_BU: begin
        misaligned_o = 1'b0;
        be_o         = 4'b0001 << addr_lo_i;
        wdata_o      = {4{sdata_i[7:0]}};
        ldata_o      = (size_i == MEM_B) ? {{24{byte_sel[7]}}, byte_sel}
                                         : {24'h0, byte_sel};
      end
      MEM_H, MEM_HU: begin
        misaligned_o = addr_lo_i[0];
        be_o         = 4'b0011 << addr_lo_i;
        wdata_o      = {2{sdata_i[15:0]}};
        ldata_o      = (size_i == MEM_H) ? {{16{half_sel[15]}}, half_sel}
                                         : {16'h0, half_sel};
      end
      MEM_W: begin
        misaligned_o = |addr_lo_i;
        be_o         = 4'b1111;
        ldata_o      = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: drives the data-memory req/ack port from the EX/MEM
// registers, stalls the front end while an access is outstanding, applies a
// bus-timeout watchdog and produces the MEM/WB registers.
module mem_stage
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  PIP_memOper_i,
  input  logic [31:0] PIP_alu_result_i,
  input  logic [31:0] PIP_second_operand_i,
  input  logic        PIP_use_mem_i,
  input  logic        PIP_write_reg_i,
  input  logic [4:0]  PIP_rd_i,
  input  logic        PIP_TRAP_i,
  mem_stage_if.master dmem,
  output logic        stall_o,
  output logic [31:0] PIP_mem_data_o,
  output logic [31:0] PIP_alu_result_o,
  output logic        PIP_use_mem_o,
  output logic        PIP_write_reg_o,
  output logic        PIP_TRAP_o,
  output logic [4:0]  PIP_rd_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  ms_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic        use_mem_q, use_mem_d;
  logic        write_reg_q, write_reg_d;
  logic        trap_q, trap_d;
  logic [4:0]  rd_q, rd_d;

  logic [3:0]  be;
  logic [31:0] wdata;
  logic        misaligned;
  logic [31:0] ldata;
  logic        mem_en, access, mis_trap, req, ack, timeout, stall;

  mem_align u_align (
    .size_i       (PIP_memOper_i[2:0]),
    .addr_lo_i    (PIP_alu_result_i[1:0]),
    .sdata_i      (PIP_second_operand_i),
    .rdata_i      (dmem.dmem_rdata_i),
    .be_o         (be),
    .wdata_o      (wdata),
    .misaligned_o (misaligned),
    .ldata_o      (ldata)
  );

  // Request/stall decode, FSM and watchdog next-state, MEM/WB next values
  always_comb begin
    mem_en   = PIP_memOper_i[MEMOP_EN_BIT] && !PIP_TRAP_i;
    access   = mem_en && !misaligned;
    mis_trap = mem_en && misaligned;
    // Reset drops the request immediately, even mid-access
    req      = access && reset_n;
    ack      = req && dmem.dmem_ack_i;
    // cnt_q holds the number of request cycles already spent without ack,
    // so the final allowed cycle is the TIMEOUT_CYCLES-th request cycle
    timeout  = req && !ack && (state_q == MS_BUSY) && (cnt_q == CNT_LAST);
    stall    = req && !ack && !timeout;

    dmem.dmem_req_o   = req;
    dmem.dmem_we_o    = req && PIP_memOper_i[MEMOP_WE_BIT];
    dmem.dmem_addr_o  = req ? {PIP_alu_result_i[31:2], 2'b00} : 32'h0;
    dmem.dmem_be_o    = req ? be : 4'b0000;
    dmem.dmem_wdata_o = req ? wdata : 32'h0;

    state_d = stall ? MS_BUSY : MS_IDLE;
    cnt_d   = stall ? cnt_q + 1'b1 : '0;

    mem_data_d   = mem_data_q;
    alu_result_d = alu_result_q;
    rd_d         = rd_q;
    use_mem_d    = 1'b0;
    write_reg_d  = 1'b0;
    trap_d       = 1'b0;
    if (stall) begin
      // bubble: controls cleared, data and rd held
    end else if (timeout || mis_trap) begin
      alu_result_d = PIP_alu_result_i;
      rd_d         = PIP_rd_i;
      trap_d       = 1'b1;
    end else begin
      alu_result_d = PIP_alu_result_i;
      rd_d         = PIP_rd_i;
      use_mem_d    = PIP_use_mem_i;
      write_reg_d  = PIP_write_reg_i;
      trap_d       = PIP_TRAP_i;
      if (ack && !PIP_memOper_i[MEMOP_WE_BIT]) mem_data_d = ldata;
    end
  end

  // FSM state, watchdog counter and MEM/WB pipeline registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= MS_IDLE;
      cnt_q        <= '0;
      mem_data_q   <= 32'h0;
      alu_result_q <= 32'h0;
      use_mem_q    <= 1'b0;
      write_reg_q  <= 1'b0;
      trap_q       <= 1'b0;
      rd_q         <= 5'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_data_q   <= mem_data_d;
      alu_result_q <= alu_result_d;
      use_mem_q    <= use_mem_d;
      write_reg_q  <= write_reg_d;
      trap_q       <= trap_d;
      rd_q         <= rd_d;
    end
  end

  assign stall_o          = stall;
  assign PIP_mem_data_o   = mem_data_q;
  assign PIP_alu_result_o = alu_result_q;
  assign PIP_use_mem_o    = use_mem_q;
  assign PIP_write_reg_o  = write_reg_q;
  assign PIP_TRAP_o       = trap_q;
  assign PIP_rd_o         = rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with a 4-cycle bus timeout.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  mem_oper;
  logic [31:0] alu_in, sop_in;
  logic        use_mem_in, write_reg_in, trap_in;
  logic [4:0]  rd_in;
  logic        stall;
  logic [31:0] mem_data_out, alu_out;
  logic        use_mem_out, write_reg_out, trap_out;
  logic [4:0]  rd_out;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .PIP_memOper_i        (mem_oper),
    .PIP_alu_result_i     (alu_in),
    .PIP_second_operand_i (sop_in),
    .PIP_use_mem_i        (use_mem_in),
    .PIP_write_reg_i      (write_reg_in),
    .PIP_rd_i             (rd_in),
    .PIP_TRAP_i           (trap_in),
    .dmem                 (bus),
    .stall_o              (stall),
    .PIP_mem_data_o       (mem_data_out),
    .PIP_alu_result_o     (alu_out),
    .PIP_use_mem_o        (use_mem_out),
    .PIP_write_reg_o      (write_reg_out),
    .PIP_TRAP_o           (trap_out),
    .PIP_rd_o             (rd_out)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] r, input logic wr, input logic um, input logic tr);
    mem_oper = op; alu_in = a; sop_in = d; rd_in = r;
    write_reg_in = wr; use_mem_in = um; trap_in = tr;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = 32'h0;
    drive(5'b10010, 32'h0000_4000, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0);
    tick; tick;
    total++; if (bus.dmem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h want=0", bus.dmem_req_o); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h want=0", stall); end
    total++; if ({alu_out, mem_data_out, rd_out, write_reg_out, use_mem_out, trap_out} !== 72'h0) begin
      bad++; $display("FAIL reset_memwb got alu=%0h data=%0h rd=%0h wr=%0h um=%0h trap=%0h want all 0",
                      alu_out, mem_data_out, rd_out, write_reg_out, use_mem_out, trap_out); end
    reset_n = 1'b1;
    drive(5'b00000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick;
  endtask

  task automatic test_nonmem;
    drive(5'b00000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (bus.dmem_req_o !== 1'b0) begin bad++; $display("FAIL nonmem_req got=%0h want=0", bus.dmem_req_o); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL nonmem_stall got=%0h want=0", stall); end
    tick;
    total++; if (alu_out !== 32'h1234) begin bad++; $display("FAIL nonmem_alu got=%0h want=1234", alu_out); end
    total++; if (rd_out !== 5'd5) begin bad++; $display("FAIL nonmem_rd got=%0d want=5", rd_out); end
    total++; if (write_reg_out !== 1'b1 || trap_out !== 1'b0) begin bad++; $display("FAIL nonmem_ctl got wr=%0h trap=%0h want wr=1 trap=0", write_reg_out, trap_out); end
  endtask

  task automatic test_store_zero_wait;
    drive(5'b11000, 32'h0000_1003, 32'h0000_00A5, 5'd3, 1'b0, 1'b0, 1'b0);
    bus.dmem_ack_i = 1'b1;
    #1;
    total++; if (bus.dmem_req_o !== 1'b1 || bus.dmem_we_o !== 1'b1) begin bad++; $display("FAIL sb_req got req=%0h we=%0h want 1 1", bus.dmem_req_o, bus.dmem_we_o); end
    total++; if (bus.dmem_be_o !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b want=1000", bus.dmem_be_o); end
    total++; if (bus.dmem_wdata_o !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_wdata got=%0h want=a5a5a5a5", bus.dmem_wdata_o); end
    total++; if (bus.dmem_addr_o !== 32'h0000_1000) begin bad++; $display("FAIL sb_addr got=%0h want=1000", bus.dmem_addr_o); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL sb_stall got=%0h want=0", stall); end
    tick;
    total++; if (alu_out !== 32'h1003 || rd_out !== 5'd3 || trap_out !== 1'b0) begin bad++; $display("FAIL sb_memwb got alu=%0h rd=%0d trap=%0h want 1003 3 0", alu_out, rd_out, trap_out); end
    drive(5'b11001, 32'h0000_1002, 32'h1234_BEEF, 5'd3, 1'b0, 1'b0, 1'b0);
    #1;
    total++; if (bus.dmem_be_o !== 4'b1100 || bus.dmem_wdata_o !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_lanes got be=%b wdata=%0h want 1100 beefbeef", bus.dmem_be_o, bus.dmem_wdata_o); end
    tick;
    bus.dmem_ack_i = 1'b0;
  endtask

  task automatic test_load_wait;
    drive(5'b10000, 32'h0000_2001, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      #1;
      total++; if (stall !== 1'b1 || bus.dmem_addr_o !== 32'h2000) begin bad++; $display("FAIL lb_stall c%0d got stall=%0h addr=%0h want 1 2000", c, stall, bus.dmem_addr_o); end
      tick;
      total++; if (write_reg_out !== 1'b0 || use_mem_out !== 1'b0 || trap_out !== 1'b0 || rd_out !== 5'd3) begin
        bad++; $display("FAIL lb_bubble c%0d got wr=%0h um=%0h trap=%0h rd=%0d want 0 0 0 3", c, write_reg_out, use_mem_out, trap_out, rd_out); end
    end
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'h0000_F200;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lb_ack_stall got=%0h want=0", stall); end
    tick;
    bus.dmem_ack_i = 1'b0;
    total++; if (mem_data_out !== 32'hFFFF_FFF2) begin bad++; $display("FAIL lb_data got=%0h want=fffffff2", mem_data_out); end
    total++; if (write_reg_out !== 1'b1 || use_mem_out !== 1'b1 || rd_out !== 5'd7) begin bad++; $display("FAIL lb_ctl got wr=%0h um=%0h rd=%0d want 1 1 7", write_reg_out, use_mem_out, rd_out); end
  endtask

  task automatic test_lhu_and_misaligned;
    drive(5'b10101, 32'h0000_2002, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'h8001_0000;
    tick;
    bus.dmem_ack_i = 1'b0;
    total++; if (mem_data_out !== 32'h0000_8001) begin bad++; $display("FAIL lhu_data got=%0h want=00008001", mem_data_out); end
    drive(5'b10010, 32'h0000_2002, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    #1;
    total++; if (bus.dmem_req_o !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL lw_mis_req got req=%0h stall=%0h want 0 0", bus.dmem_req_o, stall); end
    tick;
    total++; if (trap_out !== 1'b1 || write_reg_out !== 1'b0 || use_mem_out !== 1'b0) begin bad++; $display("FAIL lw_mis_trap got trap=%0h wr=%0h um=%0h want 1 0 0", trap_out, write_reg_out, use_mem_out); end
  endtask

  task automatic test_timeout;
    drive(5'b10010, 32'h0000_3000, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    bus.dmem_ack_i = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      #1;
      total++; if (bus.dmem_req_o !== 1'b1 || stall !== (c < TO)) begin bad++; $display("FAIL to_req c%0d got req=%0h stall=%0h want 1 %0d", c, bus.dmem_req_o, stall, c < TO); end
      tick;
      if (c < TO) begin
        total++; if (trap_out !== 1'b0 || write_reg_out !== 1'b0) begin bad++; $display("FAIL to_bubble c%0d got trap=%0h wr=%0h want 0 0", c, trap_out, write_reg_out); end
      end else begin
        total++; if (trap_out !== 1'b1 || write_reg_out !== 1'b0) begin bad++; $display("FAIL to_trap got trap=%0h wr=%0h want 1 0", trap_out, write_reg_out); end
      end
    end
    drive(5'b00000, 32'h0000_0055, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
    bus.dmem_ack_i = 1'b1;
    #1;
    total++; if (bus.dmem_req_o !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL stray_req got req=%0h stall=%0h want 0 0", bus.dmem_req_o, stall); end
    tick;
    bus.dmem_ack_i = 1'b0;
    total++; if (trap_out !== 1'b0 || write_reg_out !== 1'b1 || alu_out !== 32'h55) begin bad++; $display("FAIL stray_memwb got trap=%0h wr=%0h alu=%0h want 0 1 55", trap_out, write_reg_out, alu_out); end
  endtask

  task automatic test_ack_last_cycle;
    drive(5'b10010, 32'h0000_3004, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c < TO; c++) begin
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL last_stall c%0d got=%0h want=1", c, stall); end
      tick;
    end
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    total++; if (bus.dmem_req_o !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL last_req got req=%0h stall=%0h want 1 0", bus.dmem_req_o, stall); end
    tick;
    bus.dmem_ack_i = 1'b0;
    total++; if (trap_out !== 1'b0 || write_reg_out !== 1'b1 || mem_data_out !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL last_done got trap=%0h wr=%0h data=%0h want 0 1 deadbeef", trap_out, write_reg_out, mem_data_out); end
  endtask

  task automatic test_reset_busy;
    drive(5'b10010, 32'h0000_3008, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0);
    bus.dmem_ack_i = 1'b0;
    tick; tick;
    reset_n = 1'b0;
    #1;
    total++; if (bus.dmem_req_o !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rstbusy_req got req=%0h stall=%0h want 0 0", bus.dmem_req_o, stall); end
    total++; if ({alu_out, mem_data_out, rd_out, write_reg_out, use_mem_out, trap_out} !== 72'h0) begin
      bad++; $display("FAIL rstbusy_memwb got alu=%0h data=%0h rd=%0h wr=%0h um=%0h trap=%0h want all 0",
                      alu_out, mem_data_out, rd_out, write_reg_out, use_mem_out, trap_out); end
    tick;
    reset_n = 1'b1;
    // a full timeout window after reset shows FSM idle and counter cleared
    test_timeout();
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_store_zero_wait();
    test_load_wait();
    test_lhu_and_misaligned();
    test_timeout();
    test_ack_last_cycle();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench watchdog expired");
  end
endmodule
